// File: rtl/rb_wr_arbiter_pkg.sv
// Shared defaults and entry layout for the round-robin write arbiter and its ring.
package rb_wr_arbiter_pkg;

    localparam int RB_NB_REQ_DEF    = 4;
    localparam int RB_DEPTH_DEF     = 512;
    localparam int RB_DWIDTH_DEF    = 64;
    localparam int RB_AF_MARGIN_DEF = 16;
    localparam int RB_MAX_MARGIN    = 2;
    localparam int RB_SWIDTH_DEF    = $clog2(RB_NB_REQ_DEF);

    // Entry layout at default widths; the top rebuilds the same {src, data} layout at its own widths.
    typedef struct packed {
        logic [RB_SWIDTH_DEF-1:0] src;
        logic [RB_DWIDTH_DEF-1:0] data;
    } rb_entry_t;

endpackage

// File: rtl/rb_wr_arbiter_if.sv
// Requester and consumer handshake bundle of the write arbiter.
interface rb_wr_arbiter_if
    import rb_wr_arbiter_pkg::*;
#(
    parameter int NB_REQ = RB_NB_REQ_DEF,
    parameter int DWIDTH = RB_DWIDTH_DEF
);
    localparam int SWIDTH = $clog2(NB_REQ);

    logic [NB_REQ-1:0]             req_valid;
    logic [NB_REQ-1:0][DWIDTH-1:0] req_data;
    logic [NB_REQ-1:0]             req_ready;
    logic                          out_valid;
    logic [DWIDTH-1:0]             out_data;
    logic [SWIDTH-1:0]             out_src;
    logic                          out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rb_wr_arbiter_prefetch_rb.sv
// Ring storage with combinational head read; stays unavailable for one cycle after reset.
module prefetch_rb #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_init
);
    localparam int AWIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic              r_init;

    assign o_init    = rst | r_init;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_init   <= 1'b1;
        end else begin
            r_init <= 1'b0;
            if (i_wr_en && !r_init)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en && !r_init)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en && !o_init)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/rb_wr_arbiter.sv
// Round-robin funnel of NB_REQ writers into one ring, with occupancy, almost-full and stall tracking.
module rb_wr_arbiter
    import rb_wr_arbiter_pkg::*;
#(
    parameter int NB_REQ    = RB_NB_REQ_DEF,
    parameter int DEPTH     = RB_DEPTH_DEF,
    parameter int DWIDTH    = RB_DWIDTH_DEF,
    parameter int AF_THRESH = DEPTH - RB_AF_MARGIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    rb_wr_arbiter_if.slave           bus,
    output logic [$clog2(DEPTH)-1:0] o_occupancy,
    output logic                     o_almost_full,
    output logic [31:0]              o_stall_cnt
);
    localparam int AWIDTH = $clog2(DEPTH);
    localparam int SWIDTH = $clog2(NB_REQ);
    localparam int EWIDTH = SWIDTH + DWIDTH;
    localparam logic [AWIDTH-1:0] MAX_FILL = AWIDTH'(DEPTH - RB_MAX_MARGIN);
    localparam logic [AWIDTH-1:0] AF_LVL   = AWIDTH'(AF_THRESH);

    typedef struct packed {
        logic [SWIDTH-1:0] src;
        logic [DWIDTH-1:0] data;
    } entry_t;

    logic [SWIDTH-1:0] r_last;
    logic [AWIDTH-1:0] r_occ;
    logic              r_af;
    logic [31:0]       r_stall;

    logic              w_init;
    logic              w_hit;
    logic [SWIDTH-1:0] w_win;
    logic              w_space;
    logic              w_grant;
    logic              w_rd;
    logic              w_stall;
    logic [AWIDTH-1:0] w_occ_nxt;
    entry_t            w_wr_entry;
    entry_t            w_rd_entry;

    // Returns {hit, index}: first valid requester scanning from last+1 with wrap.
    function automatic logic [SWIDTH:0] rr_pick(input logic [NB_REQ-1:0] v,
                                                input logic [SWIDTH-1:0] last);
        logic [SWIDTH:0]   res;
        logic [SWIDTH-1:0] sel;
        int                idx;
        res = '0;
        for (int k = 1; k <= NB_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NB_REQ)
                idx = idx - NB_REQ;
            sel = SWIDTH'(idx);
            if (!res[SWIDTH] && v[sel])
                res = {1'b1, sel};
        end
        return res;
    endfunction

    always_comb begin
        {w_hit, w_win}  = rr_pick(bus.req_valid, r_last);
        w_space         = (r_occ < MAX_FILL) && !w_init;
        w_grant         = w_hit && w_space;
        w_rd            = (r_occ != '0) && bus.out_ready && !w_init;
        w_stall         = (|bus.req_valid) && !w_init && (r_occ >= MAX_FILL);
        w_occ_nxt       = r_occ;
        if (w_grant && !w_rd)
            w_occ_nxt = r_occ + 1'b1;
        else if (!w_grant && w_rd)
            w_occ_nxt = r_occ - 1'b1;
        w_wr_entry.src  = w_win;
        w_wr_entry.data = bus.req_data[w_win];
    end

    assign bus.req_ready = w_grant ? (NB_REQ'(1) << w_win) : '0;
    assign bus.out_valid = (r_occ != '0);
    assign bus.out_data  = w_rd_entry.data;
    assign bus.out_src   = w_rd_entry.src;
    assign o_occupancy   = r_occ;
    assign o_almost_full = r_af;
    assign o_stall_cnt   = r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= SWIDTH'(NB_REQ - 1);
            r_occ   <= '0;
            r_af    <= 1'b0;
            r_stall <= '0;
        end else begin
            if (w_grant)
                r_last <= w_win;
            r_occ <= w_occ_nxt;
            r_af  <= (w_occ_nxt >= AF_LVL);
            if (w_stall && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
        end
    end

    prefetch_rb #(
        .DEPTH (DEPTH),
        .WIDTH (EWIDTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_grant),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd),
        .o_rd_data (w_rd_entry),
        .o_init    (w_init)
    );

endmodule

// File: tb/tb_rb_wr_arbiter.sv
// Directed bench: default-size instance for arbitration/ordering/reset, DEPTH=16 instance for full/AF/wrap.
module tb_rb_wr_arbiter;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [8:0]  occ_a;
    logic [3:0]  occ_b;
    logic        af_a, af_b;
    logic [31:0] stall_a, stall_b;
    int n_tests = 0;
    int n_fail  = 0;
    int acc;

    always #5 clk = ~clk;

    rb_wr_arbiter_if #(.NB_REQ(4), .DWIDTH(64)) bus_a ();
    rb_wr_arbiter_if #(.NB_REQ(4), .DWIDTH(64)) bus_b ();

    rb_wr_arbiter u_a (
        .clk(clk), .rst(rst_a), .bus(bus_a),
        .o_occupancy(occ_a), .o_almost_full(af_a), .o_stall_cnt(stall_a)
    );

    rb_wr_arbiter #(.NB_REQ(4), .DEPTH(16), .DWIDTH(64), .AF_THRESH(8)) u_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .o_occupancy(occ_b), .o_almost_full(af_b), .o_stall_cnt(stall_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        bus_b.req_valid = '0;
        bus_b.out_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.out_ready = 1'b0;
        bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state, requests ignored while rst is high
        bus_a.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) bus_a.req_data[i] = 64'hA0 + 64'(i);
        #1;
        chk("rst_occ", 64'(occ_a), 0);
        chk("rst_oval", 64'(bus_a.out_valid), 0);
        chk("rst_af", 64'(af_a), 0);
        chk("rst_stall", 64'(stall_a), 0);
        chk("rst_rdy", 64'(bus_a.req_ready), 0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1 chk("guard_rdy", 64'(bus_a.req_ready), 0);
        @(negedge clk);

        // round-robin with all requesters valid, consumer always ready
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_rdy", 64'(bus_a.req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("rr_src", 64'(bus_a.out_src), 64'((k - 1) % 4));
                chk("rr_data", bus_a.out_data, 64'hA0 + 64'((k - 1) % 4));
            end
            @(negedge clk);
        end
        bus_a.req_valid = '0;
        @(negedge clk);
        #1 chk("rr_drain_occ", 64'(occ_a), 0);
        chk("rr_drain_oval", 64'(bus_a.out_valid), 0);

        // single requester burst then ordered drain
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_a.req_valid = 4'b0100;
            bus_a.req_data[2] = 64'h10 + 64'(i);
            #1 chk("burst_rdy", 64'(bus_a.req_ready), 64'h4);
            @(negedge clk);
        end
        bus_a.req_valid = '0;
        #1;
        chk("burst_occ", 64'(occ_a), 16);
        chk("burst_src", 64'(bus_a.out_src), 2);
        bus_a.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            #1 chk("drain_data", bus_a.out_data, 64'h10 + 64'(j));
            @(negedge clk);
        end
        #1;
        chk("drain_occ", 64'(occ_a), 0);
        chk("drain_oval", 64'(bus_a.out_valid), 0);
        bus_a.out_ready = 1'b0;

        // reset mid-operation at occupancy 10
        for (int i = 0; i < 10; i++) begin
            bus_a.req_valid = 4'b1000;
            bus_a.req_data[3] = 64'h30 + 64'(i);
            @(negedge clk);
        end
        #1 chk("pre_rst_occ", 64'(occ_a), 10);
        rst_a = 1'b1;
        bus_a.req_valid = 4'hF;
        #1 chk("mid_rst_rdy", 64'(bus_a.req_ready), 0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("post_rst_occ", 64'(occ_a), 0);
        chk("post_rst_oval", 64'(bus_a.out_valid), 0);
        chk("post_rst_guard", 64'(bus_a.req_ready), 0);
        @(negedge clk);
        #1 chk("post_rst_first", 64'(bus_a.req_ready), 64'h1);
        bus_a.req_valid = '0;

        // DEPTH=16: fill to MAX_FILL, stall counting, read releases one slot
        bus_b.req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus_b.req_data[0] = 64'h200 + 64'(c);
            #1 if (bus_b.req_ready[0]) acc++;
            @(negedge clk);
        end
        #1;
        chk("full_accepts", 64'(acc), 14);
        chk("full_occ", 64'(occ_b), 14);
        chk("full_stall", stall_b, 6);
        chk("full_rdy", 64'(bus_b.req_ready), 0);
        @(negedge clk);
        #1 chk("full_stall_inc", stall_b, 7);
        bus_b.out_ready = 1'b1;
        #1;
        chk("full_rd_rdy", 64'(bus_b.req_ready), 0);
        chk("full_head", bus_b.out_data, 64'h200);
        @(negedge clk);
        bus_b.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            bus_b.req_data[0] = 64'h300 + 64'(c);
            #1 if (bus_b.req_ready[0]) acc++;
            @(negedge clk);
        end
        #1;
        chk("refill_accepts", 64'(acc), 1);
        chk("refill_occ", 64'(occ_b), 14);

        // almost_full threshold 8
        reset_b();
        bus_b.req_valid = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            bus_b.req_data[0] = 64'h400 + 64'(i);
            @(negedge clk);
        end
        #1;
        chk("af7_occ", 64'(occ_b), 7);
        chk("af7", 64'(af_b), 0);
        @(negedge clk);
        #1;
        chk("af8_occ", 64'(occ_b), 8);
        chk("af8", 64'(af_b), 1);
        bus_b.req_valid = '0;
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("af_rd_occ", 64'(occ_b), 7);
        chk("af_rd", 64'(af_b), 0);

        // steady occupancy 5 with simultaneous accept/read across the ring wrap
        reset_b();
        bus_b.req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            bus_b.req_data[0] = 64'h500 + 64'(i);
            @(negedge clk);
        end
        #1 chk("ss_occ5", 64'(occ_b), 5);
        bus_b.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus_b.req_data[0] = 64'h505 + 64'(k);
            #1;
            chk("ss_data", bus_b.out_data, 64'h500 + 64'(k));
            chk("ss_rdy", 64'(bus_b.req_ready), 64'h1);
            @(negedge clk);
        end
        bus_b.req_valid = '0;
        bus_b.out_ready = 1'b0;
        #1;
        chk("ss_occ_end", 64'(occ_b), 5);
        chk("ss_head_end", bus_b.out_data, 64'h500 + 64'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rb_wr_arbiter.md
RB_WR_ARBITER -- requirements
Module: rb_wr_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter DEPTH, default 512: ring depth, power of two.
REQ-003 SHALL have parameter DWIDTH, default 64: payload width.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-16: almost_full threshold.
REQ-005 SHALL derive AWIDTH = clog2(DEPTH) and SWIDTH = clog2(NB_REQ).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  NB_REQ  per-requester payload valid.
REQ-010 req_data  in  NB_REQ x DWIDTH  per-requester payload.
REQ-011 req_ready  out  NB_REQ  one-hot grant; transfer when valid and ready are both high.
REQ-012 out_valid  out  1  head entry available.
REQ-013 out_data  out  DWIDTH  head entry payload.
REQ-014 out_src  out  SWIDTH  requester index that wrote the head entry.
REQ-015 out_ready  in  1  consumer accepts head entry when out_valid is high.
REQ-016 occupancy  out  AWIDTH  registered entry count.
REQ-017 almost_full  out  1  registered, high when occupancy >= AF_THRESH.
REQ-018 stall_cnt  out  32  saturating count of space-blocked cycles.

Function
REQ-019 SHALL define MAX_FILL = DEPTH-2; accept only while occupancy < MAX_FILL and not in reset guard (REQ-032).
REQ-020 SHALL grant at most one requester per cycle, round-robin: search starts at last_grant+1 mod NB_REQ, first requester with req_valid high wins.
REQ-021 req_ready SHALL be combinational: high only for the winner in the cycle its transfer occurs; all others are low.
REQ-022 last_grant SHALL update to the winner index on a transfer, otherwise hold.
REQ-023 A transfer SHALL write {winner index, req_data[winner]} into the ring the same cycle: ring wr_en = any req_ready.
REQ-024 The entry accepted in cycle t SHALL be visible on out_valid/out_data/out_src no earlier than cycle t+1; FIFO order is preserved.
REQ-025 out_valid SHALL equal (occupancy > 0); out_data and out_src SHALL come from the ring read data.
REQ-026 Ring rd_en SHALL equal out_valid && out_ready; the next entry is presented in cycle t+1.
REQ-027 occupancy SHALL update next = occupancy + accept - read; a simultaneous accept and read leaves it unchanged.
REQ-028 With occupancy = MAX_FILL and a read in the same cycle, there SHALL be no accept in that cycle; accepts resume the next cycle.
REQ-029 Reading at occupancy 0 SHALL be impossible: rd_en is 0.
REQ-030 stall_cnt SHALL increment when any req_valid is high and no grant is given due to REQ-019; it saturates at 0xFFFFFFFF.
REQ-031 Index wrap SHALL be modulo DEPTH for the ring and modulo NB_REQ for round-robin, with no lost or duplicated entries.

Reset
REQ-032 While rst is high, and for 1 cycle after it falls (ring internal reset lag), req_ready SHALL be all 0 and rd_en SHALL be 0.
REQ-033 Reset SHALL give occupancy=0, out_valid=0, almost_full=0, stall_cnt=0, last_grant=NB_REQ-1 (requester 0 has first priority).
REQ-034 Reset mid-operation SHALL discard all stored entries; out_data/out_src are don't-care while out_valid is 0.

Structure
REQ-035 A shared package SHALL hold the default parameter values, MAX_FILL margin (2) and the {src, data} entry struct typedef.
REQ-036 SHALL instantiate exactly one sub-module: prefetch_rb (DEPTH, DWIDTH+SWIDTH) as storage; arbitration and counting stay in this block.

Verification
REQ-037 Reset, then req_valid=4'b1111 held with out_ready=1 -> grants 0,1,2,3,0,... one per cycle, out_src follows the same order from the cycle after the first grant.
REQ-038 Only requester 2 valid, data 0x10..0x1F, out_ready=0 -> 16 transfers on back-to-back cycles, occupancy=16; then out_ready=1 -> 0x10..0x1F out in order, occupancy returns to 0.
REQ-039 DEPTH=16, out_ready=0, requester 0 always valid -> exactly 14 accepts, then req_ready=0, stall_cnt increments every cycle; one read -> exactly one further accept.
REQ-040 Occupancy 5, simultaneous accept and read each cycle for 100 cycles -> occupancy stays 5, no data loss, with wrap over the DEPTH boundary.
REQ-041 Assert rst for 1 cycle at occupancy 10 -> out_valid=0 and occupancy=0 after reset; req_ready stays 0 in the rst cycle and the following cycle; first grant goes to requester 0.
REQ-042 AF_THRESH=8: fill to 7 -> almost_full=0; the 8th accept -> almost_full=1 the next cycle; one read -> almost_full=0.
